// File: rtl/button_conditioner.sv
// Debounced, synchronised left/right/throw command pulses for the breakout game (buttonclk domain).
// Define BTN_AUTOREPEAT_EN to build hold-to-repeat on left/right; otherwise every press yields one pulse.
module button_conditioner #(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 3,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic buttonclk,
    input  logic reset,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_throw,
    output logic left,
    output logic right,
    output logic throw,
    output logic left_held,
    output logic right_held,
    output logic throw_held
);

    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic IDLE_LVL = BTN_ACTIVE_LOW;
    localparam int CH_L = 0;
    localparam int CH_R = 1;
    localparam int CH_T = 2;

    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       w_level;
    logic [2:0]       r_deb;
    logic [2:0]       w_debNext;
    logic [2:0]       w_rise;
    logic [CNT_W-1:0] r_cnt [3];
    logic             w_lock;
    logic             w_leftFire;
    logic             w_rightFire;
    logic             r_left;
    logic             r_right;
    logic             r_throw;

    assign w_raw = {raw_throw, raw_right, raw_left};

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_sync1 <= {3{IDLE_LVL}};
            r_sync2 <= {3{IDLE_LVL}};
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // The level flips only after DEBOUNCE_TICKS consecutive disagreeing samples.
    always_comb begin
        w_debNext = r_deb;
        for (int ch = 0; ch < 3; ch++) begin
            if ((w_level[ch] != r_deb[ch]) && (r_cnt[ch] == CNT_MAX)) begin
                w_debNext[ch] = w_level[ch];
            end
        end
    end

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_deb <= 3'b000;
            for (int ch = 0; ch < 3; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_deb <= w_debNext;
            for (int ch = 0; ch < 3; ch++) begin
                if (w_level[ch] != r_deb[ch]) begin
                    if (r_cnt[ch] == CNT_MAX) begin
                        r_cnt[ch] <= '0;
                    end else begin
                        r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[ch] <= '0;
                end
            end
        end
    end

    assign w_rise = w_debNext & ~r_deb;
    assign w_lock = w_debNext[CH_L] & w_debNext[CH_R];

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } repState_t;

    repState_t  r_state [2];
    logic [7:0] r_timer [2];
    logic [1:0] w_fall;
    logic [1:0] w_repHit;

    assign w_fall = r_deb[1:0] & ~w_debNext[1:0];

    // A release on the same edge as a timer hit wins, so no stray pulse escapes.
    always_comb begin
        w_repHit = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (!w_fall[ch]) begin
                if ((r_state[ch] == DELAY) && (r_timer[ch] == 8'(REPEAT_DELAY))) begin
                    w_repHit[ch] = 1'b1;
                end
                if ((r_state[ch] == REPEAT) && (r_timer[ch] == 8'(REPEAT_RATE))) begin
                    w_repHit[ch] = 1'b1;
                end
            end
        end
    end

    // Timers start on the debounced press even if lockout hides that pulse.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_state[ch] <= IDLE;
                r_timer[ch] <= 8'd0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (w_fall[ch]) begin
                    r_state[ch] <= IDLE;
                    r_timer[ch] <= 8'd0;
                end else begin
                    case (r_state[ch])
                        IDLE: begin
                            if (w_rise[ch]) begin
                                r_state[ch] <= DELAY;
                                r_timer[ch] <= 8'd1;
                            end
                        end
                        DELAY: begin
                            if (r_timer[ch] == 8'(REPEAT_DELAY)) begin
                                r_state[ch] <= REPEAT;
                                r_timer[ch] <= 8'd1;
                            end else begin
                                r_timer[ch] <= r_timer[ch] + 8'd1;
                            end
                        end
                        REPEAT: begin
                            if (r_timer[ch] == 8'(REPEAT_RATE)) begin
                                r_timer[ch] <= 8'd1;
                            end else begin
                                r_timer[ch] <= r_timer[ch] + 8'd1;
                            end
                        end
                        default: begin
                            r_state[ch] <= IDLE;
                            r_timer[ch] <= 8'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign w_leftFire  = w_rise[CH_L] | w_repHit[CH_L];
    assign w_rightFire = w_rise[CH_R] | w_repHit[CH_R];
`else
    assign w_leftFire  = w_rise[CH_L];
    assign w_rightFire = w_rise[CH_R];
`endif

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_throw <= 1'b0;
        end else begin
            r_left  <= w_leftFire & ~w_lock;
            r_right <= w_rightFire & ~w_lock;
            r_throw <= w_rise[CH_T];
        end
    end

    assign left       = r_left;
    assign right      = r_right;
    assign throw      = r_throw;
    assign left_held  = r_deb[CH_L];
    assign right_held = r_deb[CH_R];
    assign throw_held = r_deb[CH_T];

endmodule
